// File: rtl/sequence_checker.sv
// Sequence memory with replay and guess-checking FSM for the symbol game.
// Optional guess timeout in CHECK: define SEQUENCE_CHECKER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | accept appends, wait for start
// PLAY  | emit one stored symbol per play_tick
// CHECK | compare guesses against the stored sequence in order
// FAIL  | wrong guess (or timeout); hold until clear
module sequence_checker #(
    parameter int N     = 3,
    parameter int DEPTH = 16,
    parameter int LEN_W = 5
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_TICKS = 8
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             append,
    input  logic [N-1:0]     symbol_in,
    input  logic             start,
    input  logic             play_tick,
    input  logic             guess_valid,
    input  logic [N-1:0]     guess,
    output logic             play_valid,
    output logic [N-1:0]     play_symbol,
    output logic             hit,
    output logic             round_ok,
    output logic             fail,
    output logic             busy,
    output logic             full,
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic [LEN_W-1:0] length
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_CHECK,
        S_FAIL
    } state_t;

    state_t           state, state_next;
    logic [N-1:0]     mem [DEPTH];
    logic [N-1:0]     mem_rd;
    logic [N-1:0]     play_symbol_next;
    logic [LEN_W-1:0] idx, idx_next, length_next, last_idx;
    logic             play_valid_next, hit_next, round_ok_next, fail_next;
    logic             mem_we;
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0]    tmo_cnt, tmo_cnt_next;
    logic             timeout_next;
`endif

    assign last_idx = length - LEN_W'(1);
    assign mem_rd   = mem[idx[AW-1:0]];

    // Storage is deliberately not reset; contents are meaningless while length is 0.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[length[AW-1:0]] <= symbol_in;
        end
    end

    always_comb begin
        state_next       = state;
        length_next      = length;
        idx_next         = idx;
        play_symbol_next = play_symbol;
        play_valid_next  = 1'b0;
        hit_next         = 1'b0;
        round_ok_next    = 1'b0;
        fail_next        = 1'b0;
        mem_we           = 1'b0;
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
        tmo_cnt_next     = tmo_cnt;
        timeout_next     = 1'b0;
`endif
        if (clear) begin
            state_next  = S_IDLE;
            length_next = '0;
            idx_next    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (append && !full) begin
                        mem_we      = 1'b1;
                        length_next = length + LEN_W'(1);
                    end
                    // start looks at the pre-append length
                    if (start && length != '0) begin
                        idx_next   = '0;
                        state_next = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (play_tick) begin
                        play_symbol_next = mem_rd;
                        play_valid_next  = 1'b1;
                        if (idx == last_idx) begin
                            idx_next   = '0;
                            state_next = S_CHECK;
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
                            tmo_cnt_next = TW'(TIMEOUT_TICKS);
`endif
                        end else begin
                            idx_next = idx + LEN_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (guess_valid) begin
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
                        tmo_cnt_next = TW'(TIMEOUT_TICKS);
`endif
                        if (guess != mem_rd) begin
                            fail_next  = 1'b1;
                            state_next = S_FAIL;
                        end else if (idx == last_idx) begin
                            round_ok_next = 1'b1;
                            idx_next      = '0;
                            state_next    = S_IDLE;
                        end else begin
                            hit_next = 1'b1;
                            idx_next = idx + LEN_W'(1);
                        end
                    end
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
                    else if (play_tick) begin
                        if (tmo_cnt == TW'(1)) begin
                            timeout_next = 1'b1;
                            fail_next    = 1'b1;
                            state_next   = S_FAIL;
                        end else begin
                            tmo_cnt_next = tmo_cnt - TW'(1);
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            length      <= '0;
            idx         <= '0;
            play_symbol <= '0;
            play_valid  <= 1'b0;
            hit         <= 1'b0;
            round_ok    <= 1'b0;
            fail        <= 1'b0;
            busy        <= 1'b0;
            full        <= 1'b0;
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
            tmo_cnt     <= TW'(TIMEOUT_TICKS);
            timeout     <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            length      <= length_next;
            idx         <= idx_next;
            play_symbol <= play_symbol_next;
            play_valid  <= play_valid_next;
            hit         <= hit_next;
            round_ok    <= round_ok_next;
            fail        <= fail_next;
            busy        <= (state_next != S_IDLE);
            full        <= (length_next == LEN_W'(DEPTH));
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
            tmo_cnt     <= tmo_cnt_next;
            timeout     <= timeout_next;
`endif
        end
    end

endmodule
